// File: rtl/isp_pkg.sv
// isp_pkg: shared Bayer channel and mosaic FSM types for the ISP pipeline
package isp_pkg;
  typedef enum logic [1:0] {CH_R, CH_G, CH_B} bayer_ch_t;
  typedef enum logic [2:0] {S_IDLE, S_SOF, S_ACTIVE, S_HBLANK, S_DONE} mosaic_state_t;
  function automatic bayer_ch_t bayer_sel(input logic row_odd, input logic col_odd);
    return (row_odd == col_odd) ? CH_G : (row_odd ? CH_R : CH_B);
  endfunction
endpackage

// File: rtl/raster_counter.sv
// raster_counter: column/row position with end-of-row and end-of-frame flags
module raster_counter #(
  parameter int width  = 320,
  parameter int height = 240
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adv,
  output logic [$clog2(width)-1:0]  col,
  output logic [$clog2(height)-1:0] row,
  output logic                      eol,
  output logic                      eof
);
  localparam int CW = $clog2(width);
  localparam int RW = $clog2(height);
  assign eol = col == CW'(width - 1);
  assign eof = eol && row == RW'(height - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      col <= eol ? '0 : col + 1'b1;
      row <= eof ? '0 : eol ? row + 1'b1 : row;
    end
endmodule

// File: rtl/bayer_mosaic_tx.sv
// bayer_mosaic_tx: subsamples RGB pixels to a framed G B / R G Bayer stream
module bayer_mosaic_tx
  import isp_pkg::*;
#(
  parameter int width  = 320,
  parameter int height = 240,
  parameter int hBlank = 16,
  parameter int sofGap = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iStart,
  input  logic       iValid,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  output logic       oReady,
  output logic       newFrame,
  output logic       oValid,
  output logic [7:0] oData,
  output logic       oDone,
  output logic       oBusy
);
  localparam int GMAX = hBlank > sofGap ? hBlank : sofGap;
  localparam int GW   = $clog2(GMAX + 1);
  mosaic_state_t state, state_n;
  logic [GW-1:0] cnt, cnt_n, last;
  logic [$clog2(width)-1:0] col;
  logic [$clog2(height)-1:0] row;
  logic eol, eof, acc, wrap;
  bayer_ch_t ch;
  logic [7:0] sample;
  assign oReady = state == S_ACTIVE;
  assign oBusy  = state != S_IDLE;
  assign acc    = iValid && oReady;
  assign ch     = bayer_sel(row[0], col[0]);
  assign sample = ch == CH_R ? iR : ch == CH_B ? iB : iG;
  // DONE spans two cycles so oDone lands one cycle after the last sample
  assign last   = state == S_SOF ? GW'(sofGap - 1) : state == S_HBLANK ? GW'(hBlank - 1) : GW'(1);
  assign wrap   = cnt == last;
  raster_counter #(.width(width), .height(height)) u_raster (
    .clk(clk), .rst(reset), .adv(acc), .col(col), .row(row), .eol(eol), .eof(eof)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    case (state)
      S_IDLE:   state_n = iStart ? S_SOF : S_IDLE;
      S_SOF: begin
        state_n = wrap ? S_ACTIVE : S_SOF;
        cnt_n   = wrap ? '0 : cnt + 1'b1;
      end
      S_ACTIVE: state_n = !(acc && eol) ? S_ACTIVE : eof ? S_DONE : S_HBLANK;
      S_HBLANK: begin
        state_n = wrap ? S_ACTIVE : S_HBLANK;
        cnt_n   = wrap ? '0 : cnt + 1'b1;
      end
      S_DONE: begin
        state_n = wrap ? S_IDLE : S_DONE;
        cnt_n   = wrap ? '0 : cnt + 1'b1;
      end
      default:  state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      newFrame <= 1'b0;
      oValid   <= 1'b0;
      oData    <= '0;
      oDone    <= 1'b0;
    end else begin
      newFrame <= state == S_IDLE && iStart;
      oValid   <= acc;
      oDone    <= state == S_DONE && !wrap;
      if (acc) oData <= sample;
    end
endmodule

// File: tb/tb_bayer_mosaic_tx.sv
// tb_bayer_mosaic_tx: directed and randomized frames checked against a raster-schedule model
module tb_bayer_mosaic_tx;
  localparam int W = 4, H = 2, HB = 2, SG = 4, N = W * H, BIG = 1 << 30;
  logic clk = 0, reset = 1, iStart = 0, iValid = 0;
  logic [7:0] iR = 0, iG = 0, iB = 0;
  logic oReady, newFrame, oValid, oDone, oBusy;
  logic [7:0] oData;
  int cyc = 0, passed = 0, total = 0;
  int nf_cyc = BIG, ready_from = BIG, done_cyc = BIG, pix = 0, nf1, nf2;
  logic exp_v = 0;
  logic [7:0] exp_d = 0;
  logic [7:0] obs_q[$];
  logic [7:0] pat [8] = '{8'd20, 8'd31, 8'd22, 8'd33, 8'd14, 8'd25, 8'd16, 8'd27};

  bayer_mosaic_tx #(.width(W), .height(H), .hBlank(HB), .sofGap(SG)) dut (
    .clk(clk), .reset(reset), .iStart(iStart), .iValid(iValid),
    .iR(iR), .iG(iG), .iB(iB), .oReady(oReady), .newFrame(newFrame),
    .oValid(oValid), .oData(oData), .oDone(oDone), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, oReady, 0);
    chk({tag, "_newframe"}, newFrame, 0);
    chk({tag, "_valid"}, oValid, 0);
    chk({tag, "_data"}, oData, 0);
    chk({tag, "_done"}, oDone, 0);
    chk({tag, "_busy"}, oBusy, 0);
  endtask

  function automatic logic [7:0] bayer(input int k, input logic [7:0] r, g, b);
    int rw = k / W, cl = k % W;
    return (rw % 2 == cl % 2) ? g : (rw % 2 == 1) ? r : b;
  endfunction

  task automatic chk_pat;
    chk("sample_count", obs_q.size(), N);
    foreach (pat[i]) if (i < obs_q.size()) chk("sample", obs_q[i], pat[i]);
  endtask

  // Starts a frame this cycle and checks every output every cycle until one cycle past oDone
  task automatic frame(input bit rnd, input int stall, input bit poke, input int abort_at);
    int stalls = stall;
    logic rdy;
    obs_q.delete();
    iStart = 1;
    nf_cyc = cyc + 1;
    ready_from = nf_cyc + SG;
    done_cyc = BIG;
    pix = 0;
    exp_v = 0;
    for (int n = 0; n < 200 && cyc != done_cyc + 1; n++) begin
      tick;
      iStart = 0;
      rdy = cyc >= ready_from && pix < N;
      chk("ready", oReady, rdy);
      chk("valid", oValid, exp_v);
      chk("data", oData, exp_d);
      chk("newframe", newFrame, cyc == nf_cyc);
      chk("done", oDone, cyc == done_cyc);
      chk("busy", oBusy, cyc >= nf_cyc && cyc <= done_cyc);
      if (oValid) obs_q.push_back(oData);
      if (abort_at == pix && rdy) begin
        reset = 1;
        iValid = 0;
        #1;
        chk_zero("abort");
        tick;
        reset = 0;
        exp_v = 0;
        exp_d = 0;
        repeat (8) begin
          tick;
          chk("abort_no_done", oDone, 0);
          chk("abort_idle", oBusy, 0);
        end
        return;
      end
      iStart = poke && rdy;
      iValid = poke ? 1'b1 : rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (pix == 2 && rdy && stalls > 0) begin
        iValid = 0;
        stalls--;
      end
      {iR, iG, iB} = rnd ? 24'($urandom) : {8'(10 + pix), 8'(20 + pix), 8'(30 + pix)};
      exp_v = iValid && rdy;
      if (exp_v) begin
        exp_d = bayer(pix, iR, iG, iB);
        if (pix % W == W - 1) ready_from = cyc + HB + 1;
        if (pix == N - 1) done_cyc = cyc + 2;
        pix++;
      end
    end
    chk("frame_end", cyc, done_cyc + 1);
  endtask

  initial begin
    tick;
    chk_zero("reset");
    tick;
    reset = 0;
    while (cyc < 10) begin
      tick;
      chk_zero("idle");
    end
    frame(0, 0, 0, -1);
    chk_pat;
    frame(0, 3, 0, -1);
    chk_pat;
    frame(0, 0, 1, -1);
    chk_pat;
    frame(0, 0, 0, 6);
    frame(0, 0, 0, -1);
    chk_pat;
    nf1 = nf_cyc;
    frame(0, 0, 0, -1);
    nf2 = nf_cyc;
    chk_pat;
    chk("newframe_gap", nf2 - nf1 - 1, 16);
    repeat (6) frame(1, 0, 0, -1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
